// File: rtl/fde_pipe_core.sv
`default_nettype none
// ============================================================================
// Module   : fde_pipe_core
// Purpose  : 3-stage (fetch / decode / execute) pipelined CPU core with a
//            loadable instruction memory, register file, ALU, RAW hazard
//            handling and HALT / stop control.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk         in   1           clock, all state on rising edge
//   i_reset       in   1           synchronous active-low reset
//   i_stop        in   1           1 = freeze pipeline this cycle
//   i_imem_we     in   1           IMEM write strobe (loader)
//   i_imem_addr   in   PC_W        IMEM write address
//   i_imem_data   in   INST_W      IMEM write data
//   o_pc          out  PC_W        current fetch address
//   o_write_en    out  1           registered writeback strobe
//   o_write_add   out  REG_ADDR_W  writeback register address
//   o_write_data  out  DATA_W      writeback data
//   o_halted      out  1           sticky HALT indication
// Build option
//   FDE_FWD_EN    defined  : distance-1 RAW hazards bypass the EX result
//                            into the decode operand mux (no stall).
//                 undefined: distance-1 RAW hazards insert one bubble.
// Instruction format: [op:4 | dst | s1 | s2], REG_ADDR_W bits per field.
// ============================================================================
module fde_pipe_core #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 4,
  parameter int IMEM_DEPTH = 16,
  localparam int INST_W    = 4 + 3 * REG_ADDR_W,
  localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stop,
  input  logic                  i_imem_we,
  input  logic [PC_W-1:0]       i_imem_addr,
  input  logic [INST_W-1:0]     i_imem_data,
  output logic [PC_W-1:0]       o_pc,
  output logic                  o_write_en,
  output logic [REG_ADDR_W-1:0] o_write_add,
  output logic [DATA_W-1:0]     o_write_data,
  output logic                  o_halted
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  // Only ops 1..9 produce a register writeback.
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  // Operand usage: a hazard only matters for fields that are really read
  // from the register file (LDI's s1/s2 form an immediate).
  function automatic logic op_uses_s1(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_MOV) ||
           (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic op_uses_s2(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [INST_W-1:0]     imem [IMEM_DEPTH];
  logic [DATA_W-1:0]     regs [NUM_REGS];
  logic [PC_W-1:0]       pc;
  logic [INST_W-1:0]     if_id;
  logic [3:0]            ex_op;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic [DATA_W-1:0]     ex_a;
  logic [DATA_W-1:0]     ex_b;
  logic                  halted;

  // --------------------------------------------------------------------------
  // Decode stage
  // --------------------------------------------------------------------------
  logic [3:0]            d_op;
  logic [REG_ADDR_W-1:0] d_dst;
  logic [REG_ADDR_W-1:0] d_s1;
  logic [REG_ADDR_W-1:0] d_s2;
  logic [DATA_W-1:0]     d_imm;
  logic [DATA_W-1:0]     d_a;
  logic [DATA_W-1:0]     d_b;
  logic                  d_is_halt;
  logic                  ex_writes;
  logic                  hit_s1;
  logic                  hit_s2;
  logic                  stall;
  logic [DATA_W-1:0]     alu_res;

  assign d_op      = if_id[INST_W-1 -: 4];
  assign d_dst     = if_id[3*REG_ADDR_W-1 -: REG_ADDR_W];
  assign d_s1      = if_id[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign d_s2      = if_id[REG_ADDR_W-1:0];
  assign d_imm     = DATA_W'({d_s1, d_s2});
  assign d_is_halt = (d_op == OP_HALT);

  // The instruction in EX writes the register file on the same edge that
  // decode samples it, so a distance-1 consumer would see the stale value.
  assign ex_writes = op_writes(ex_op);
  assign hit_s1    = ex_writes && op_uses_s1(d_op) && (ex_dst == d_s1);
  assign hit_s2    = ex_writes && op_uses_s2(d_op) && (ex_dst == d_s2);

`ifdef FDE_FWD_EN
  assign stall = 1'b0;
  always_comb begin
    d_a = hit_s1 ? alu_res : regs[d_s1];
    d_b = hit_s2 ? alu_res : regs[d_s2];
    if (d_op == OP_LDI) begin
      d_a = d_imm;
    end
  end
`else
  assign stall = hit_s1 || hit_s2;
  always_comb begin
    d_a = regs[d_s1];
    d_b = regs[d_s2];
    if (d_op == OP_LDI) begin
      d_a = d_imm;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Execute stage ALU (LDI immediate travels in the A operand)
  // --------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    case (ex_op)
      OP_ADD:  alu_res = ex_a + ex_b;
      OP_SUB:  alu_res = ex_a - ex_b;
      OP_AND:  alu_res = ex_a & ex_b;
      OP_OR:   alu_res = ex_a | ex_b;
      OP_XOR:  alu_res = ex_a ^ ex_b;
      OP_LDI:  alu_res = ex_a;
      OP_MOV:  alu_res = ex_a;
      OP_SHL:  alu_res = ex_a << 1;
      OP_SHR:  alu_res = ex_a >> 1;
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction memory: never reset, writable at any time. The fetch below
  // samples imem[pc] with a non-blocking read, so a same-edge write to the
  // fetch address returns the old word.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_imem_we) begin
      imem[i_imem_addr] <= i_imem_data;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers. Priority: reset > stop > stall > halt > normal.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc           <= '0;
      if_id        <= '0;
      ex_op        <= OP_NOP;
      ex_dst       <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      halted       <= 1'b0;
      o_write_en   <= 1'b0;
      o_write_add  <= '0;
      o_write_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (i_stop) begin
      // Everything holds; only the strobe drops so no write is repeated.
      o_write_en <= 1'b0;
    end else begin
      // Execute / writeback always advances when not stopped.
      o_write_en <= ex_writes;
      if (ex_writes) begin
        o_write_add  <= ex_dst;
        o_write_data <= alu_res;
        regs[ex_dst] <= alu_res;
      end

      if (stall) begin
        // pc and IF/ID hold; bubble into EX.
        ex_op  <= OP_NOP;
        ex_dst <= '0;
        ex_a   <= '0;
        ex_b   <= '0;
      end else if (d_is_halt || halted) begin
        // Once halted the front end is parked: pc frozen, NOPs flow down.
        halted <= 1'b1;
        if_id  <= '0;
        ex_op  <= OP_NOP;
        ex_dst <= '0;
        ex_a   <= '0;
        ex_b   <= '0;
      end else begin
        if_id  <= imem[pc];
        pc     <= pc + PC_W'(1);
        ex_op  <= d_op;
        ex_dst <= d_dst;
        ex_a   <= d_a;
        ex_b   <= d_b;
      end
    end
  end

  assign o_pc     = pc;
  assign o_halted = halted;

endmodule
`default_nettype wire

// File: tb/tb_fde_pipe_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fde_pipe_core
// Purpose  : Directed self-checking bench for fde_pipe_core. Each program is
//            loaded while reset is held low, then reset is released and the
//            outputs are logged after every rising edge (edge 1 = first edge
//            with reset high). Expected write timing depends on FDE_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fde_pipe_core;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 4;
  localparam int IMEM_DEPTH = 16;
  localparam int INST_W     = 16;
  localparam int PC_W       = 4;
  localparam int MAXE       = 48;

`ifdef FDE_FWD_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  stop;
  logic                  we;
  logic [PC_W-1:0]       waddr;
  logic [INST_W-1:0]     wdata;
  logic [PC_W-1:0]       pc;
  logic                  wen;
  logic [REG_ADDR_W-1:0] wadd;
  logic [DATA_W-1:0]     wdat;
  logic                  halted;

  int total = 0;
  int bad   = 0;

  logic [INST_W-1:0]     prog     [IMEM_DEPTH];
  logic                  we_log   [MAXE+1];
  logic [REG_ADDR_W-1:0] add_log  [MAXE+1];
  logic [DATA_W-1:0]     data_log [MAXE+1];
  logic [PC_W-1:0]       pc_log   [MAXE+1];
  logic                  halt_log [MAXE+1];
  logic [MAXE:0]         stop_mask;

  fde_pipe_core #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_stop       (stop),
    .i_imem_we    (we),
    .i_imem_addr  (waddr),
    .i_imem_data  (wdata),
    .o_pc         (pc),
    .o_write_en   (wen),
    .o_write_add  (wadd),
    .o_write_data (wdat),
    .o_halted     (halted)
  );

  function automatic logic [INST_W-1:0] ins(input logic [3:0] op, input logic [3:0] d,
                                            input logic [3:0] a, input logic [3:0] b);
    return {op, d, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IMEM_DEPTH; i++) prog[i] = '0;
    stop_mask = '0;
  endtask

  // Load the whole IMEM with reset held low.
  task automatic load_and_reset();
    rst_n = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      we    = 1'b1;
      waddr = PC_W'(i);
      wdata = prog[i];
      tick();
    end
    we = 1'b0;
    tick();
  endtask

  // Release reset and log outputs after edges 1..n.
  task automatic run(input int n);
    rst_n = 1'b1;
    for (int k = 1; k <= n; k++) begin
      stop = stop_mask[k];
      tick();
      we_log[k]   = wen;
      add_log[k]  = wadd;
      data_log[k] = wdat;
      pc_log[k]   = pc;
      halt_log[k] = halted;
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = ins(4'h6, 4'h1, 4'h0, 4'h5);
    prog[1] = ins(4'h6, 4'h2, 4'h0, 4'h3);
    prog[2] = ins(4'h1, 4'h3, 4'h1, 4'h2);
    load_and_reset();
    run(6);
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (pc !== 4'd0)    begin bad++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    total++; if (wen !== 1'b0)   begin bad++; $display("FAIL reset_wen: got %b expected 0", wen); end
    total++; if (wadd !== 4'd0)  begin bad++; $display("FAIL reset_wadd: got %0d expected 0", wadd); end
    total++; if (wdat !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h expected 00", wdat); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b expected 0", halted); end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (pc !== PC_W'(k)) begin bad++; $display("FAIL reset_release_pc[%0d]: got %0d expected %0d", k, pc, k); end
    end
  endtask

  task automatic test_add();
    logic                  exp_en;
    logic [REG_ADDR_W-1:0] ea;
    logic [DATA_W-1:0]     ed;
    clear_prog();
    prog[0] = ins(4'h6, 4'h1, 4'h0, 4'h5);
    prog[1] = ins(4'h6, 4'h2, 4'h0, 4'h3);
    prog[2] = ins(4'h1, 4'h3, 4'h1, 4'h2);
    load_and_reset();
    run(10);
    for (int k = 1; k <= 10; k++) begin
      exp_en = 1'b0; ea = '0; ed = '0;
      if (k == 3)       begin exp_en = 1'b1; ea = 4'd1; ed = 8'h05; end
      if (k == 4)       begin exp_en = 1'b1; ea = 4'd2; ed = 8'h03; end
      if (k == 5 + GAP) begin exp_en = 1'b1; ea = 4'd3; ed = 8'h08; end
      total++;
      if (we_log[k] !== exp_en) begin bad++; $display("FAIL add_wen[%0d]: got %b expected %b", k, we_log[k], exp_en); end
      if (exp_en) begin
        total++;
        if ({add_log[k], data_log[k]} !== {ea, ed}) begin
          bad++; $display("FAIL add_write[%0d]: got (%0d,%h) expected (%0d,%h)", k, add_log[k], data_log[k], ea, ed);
        end
      end
    end
  endtask

  task automatic test_sub_shl();
    logic                  exp_en;
    logic [REG_ADDR_W-1:0] ea;
    logic [DATA_W-1:0]     ed;
    clear_prog();
    prog[0] = ins(4'h6, 4'h1, 4'h0, 4'h3);
    prog[1] = ins(4'h6, 4'h2, 4'h0, 4'h5);
    prog[3] = ins(4'h2, 4'h4, 4'h1, 4'h2);
    prog[4] = ins(4'h8, 4'h5, 4'h4, 4'h0);
    load_and_reset();
    run(12);
    for (int k = 1; k <= 12; k++) begin
      exp_en = 1'b0; ea = '0; ed = '0;
      if (k == 3)       begin exp_en = 1'b1; ea = 4'd1; ed = 8'h03; end
      if (k == 4)       begin exp_en = 1'b1; ea = 4'd2; ed = 8'h05; end
      if (k == 6)       begin exp_en = 1'b1; ea = 4'd4; ed = 8'hFE; end
      if (k == 7 + GAP) begin exp_en = 1'b1; ea = 4'd5; ed = 8'hFC; end
      total++;
      if (we_log[k] !== exp_en) begin bad++; $display("FAIL subshl_wen[%0d]: got %b expected %b", k, we_log[k], exp_en); end
      if (exp_en) begin
        total++;
        if ({add_log[k], data_log[k]} !== {ea, ed}) begin
          bad++; $display("FAIL subshl_write[%0d]: got (%0d,%h) expected (%0d,%h)", k, add_log[k], data_log[k], ea, ed);
        end
      end
    end
  endtask

  task automatic test_stop();
    logic                  exp_en;
    logic [REG_ADDR_W-1:0] ea;
    logic [DATA_W-1:0]     ed;
    clear_prog();
    prog[0] = ins(4'h6, 4'h1, 4'h0, 4'h5);
    prog[1] = ins(4'h6, 4'h2, 4'h0, 4'h3);
    prog[2] = ins(4'h1, 4'h3, 4'h1, 4'h2);
    load_and_reset();
    stop_mask[4] = 1'b1;
    stop_mask[5] = 1'b1;
    run(12);
    for (int k = 1; k <= 12; k++) begin
      exp_en = 1'b0; ea = '0; ed = '0;
      if (k == 3)       begin exp_en = 1'b1; ea = 4'd1; ed = 8'h05; end
      if (k == 6)       begin exp_en = 1'b1; ea = 4'd2; ed = 8'h03; end
      if (k == 7 + GAP) begin exp_en = 1'b1; ea = 4'd3; ed = 8'h08; end
      total++;
      if (we_log[k] !== exp_en) begin bad++; $display("FAIL stop_wen[%0d]: got %b expected %b", k, we_log[k], exp_en); end
      if (exp_en) begin
        total++;
        if ({add_log[k], data_log[k]} !== {ea, ed}) begin
          bad++; $display("FAIL stop_write[%0d]: got (%0d,%h) expected (%0d,%h)", k, add_log[k], data_log[k], ea, ed);
        end
      end
    end
    total++; if (pc_log[5] !== 4'd3) begin bad++; $display("FAIL stop_pc_hold: got %0d expected 3", pc_log[5]); end
    total++;
    if ({add_log[5], data_log[5]} !== {4'd1, 8'h05}) begin
      bad++; $display("FAIL stop_data_hold: got (%0d,%h) expected (1,05)", add_log[5], data_log[5]);
    end
  endtask

  task automatic test_halt();
    clear_prog();
    prog[0] = ins(4'h6, 4'h1, 4'h1, 4'h1);
    prog[1] = ins(4'hF, 4'h0, 4'h0, 4'h0);
    prog[2] = ins(4'h6, 4'h4, 4'h2, 4'h2);
    load_and_reset();
    run(12);
    total++; if (halt_log[2] !== 1'b0) begin bad++; $display("FAIL halt_early: got %b expected 0", halt_log[2]); end
    for (int k = 1; k <= 12; k++) begin
      total++;
      if (we_log[k] !== (k == 3)) begin bad++; $display("FAIL halt_wen[%0d]: got %b expected %b", k, we_log[k], (k == 3)); end
      if (k >= 2) begin
        total++;
        if (pc_log[k] !== 4'd2) begin bad++; $display("FAIL halt_pc[%0d]: got %0d expected 2", k, pc_log[k]); end
      end
      if (k >= 3) begin
        total++;
        if (halt_log[k] !== 1'b1) begin bad++; $display("FAIL halt_flag[%0d]: got %b expected 1", k, halt_log[k]); end
      end
    end
    total++;
    if ({add_log[3], data_log[3]} !== {4'd1, 8'h11}) begin
      bad++; $display("FAIL halt_write: got (%0d,%h) expected (1,11)", add_log[3], data_log[3]);
    end
  endtask

  task automatic test_wrap();
    logic exp_en;
    clear_prog();
    prog[0] = ins(4'h6, 4'h7, 4'h5, 4'hA);
    load_and_reset();
    run(40);
    for (int k = 1; k <= 40; k++) begin
      exp_en = (k == 3) || (k == 19) || (k == 35);
      total++;
      if (we_log[k] !== exp_en) begin bad++; $display("FAIL wrap_wen[%0d]: got %b expected %b", k, we_log[k], exp_en); end
      if (exp_en) begin
        total++;
        if ({add_log[k], data_log[k]} !== {4'd7, 8'h5A}) begin
          bad++; $display("FAIL wrap_write[%0d]: got (%0d,%h) expected (7,5a)", k, add_log[k], data_log[k]);
        end
      end
    end
    total++; if (pc_log[15] !== 4'd15) begin bad++; $display("FAIL wrap_pc15: got %0d expected 15", pc_log[15]); end
    total++; if (pc_log[16] !== 4'd0)  begin bad++; $display("FAIL wrap_pc16: got %0d expected 0", pc_log[16]); end
    total++; if (pc_log[17] !== 4'd1)  begin bad++; $display("FAIL wrap_pc17: got %0d expected 1", pc_log[17]); end
  endtask

  initial begin
    rst_n = 1'b0;
    stop  = 1'b0;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    stop_mask = '0;
    test_reset();
    test_add();
    test_sub_shl();
    test_stop();
    test_halt();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
